// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect/verify, oversampled data/stop sampling, LSB-first assembly.
// Optional even-parity check is enabled with `define PARITY_CHECK_EN.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef PARITY_CHECK_EN
  logic                 par_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      if (sample_tick) begin
        case (state)
          IDLE: if (!rxs) begin
            state <= START;
            tcnt  <= '0;
          end
          // Half a bit in: a high line here was a glitch, drop back silently.
          START: if (tcnt == T_HALF) begin
            tcnt  <= '0;
            bcnt  <= '0;
            state <= rxs ? IDLE : DATA;
          end else tcnt <= tcnt + 1'b1;
          DATA: if (tcnt == T_LAST) begin
            tcnt  <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == B_LAST) begin
`ifdef PARITY_CHECK_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else tcnt <= tcnt + 1'b1;
`ifdef PARITY_CHECK_EN
          PARITY: if (tcnt == T_LAST) begin
            tcnt    <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else tcnt <= tcnt + 1'b1;
`endif
          STOP: if (tcnt == T_LAST) begin
            tcnt  <= '0;
            state <= IDLE;
            if (rxs) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
`ifdef PARITY_CHECK_EN
            parity_err <= ^{shreg, par_bit};
`endif
          end else tcnt <= tcnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

  assign rx_busy = (state != IDLE);
endmodule
